// File: rtl/if_id_pkg.sv
// Shared fetch/decode widths and constants for the IF/ID stage.
// These match the values in the shared defines.v.
package if_id_pkg;

   localparam int unsigned InstAddrBus = 32;
   localparam int unsigned InstBus     = 32;
   localparam logic [31:0] ZeroWord    = 32'h0000_0000;
   localparam logic        ChipEnable  = 1'b1;
   localparam logic        ChipDisable = 1'b0;
   localparam int unsigned IfIdDepth   = 2;
   // Occupancy counter width, i.e. IfIdCntBus = 1:0.
   localparam int unsigned IfIdCntW    = 2;

   typedef logic [InstAddrBus-1:0] inst_addr_t;
   typedef logic [InstBus-1:0]     inst_t;
   typedef logic [IfIdCntW-1:0]    cnt_t;

   typedef struct packed {
      inst_addr_t pc;
      inst_t      inst;
   } if_id_entry_t;

   function automatic logic cnt_full(input cnt_t c);
      return c >= cnt_t'(IfIdDepth);
   endfunction

endpackage

// File: rtl/if_id_skid.sv
// Two-entry in-order storage for the IF/ID stage: storage array, 1-bit wrapping
// pointers and an occupancy counter. Handshake and flush policy live in if_id.
module if_id_skid
   import if_id_pkg::*;
#(
   parameter int unsigned DEPTH = IfIdDepth
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  if_id_entry_t wr_entry,
   output if_id_entry_t head,
   output cnt_t         count,
   output cnt_t         count_next
);

   if_id_entry_t mem [DEPTH];
   logic         wr_ptr;
   logic         rd_ptr;
   cnt_t         count_q;
   logic         push_ok;
   logic         pop_ok;

   assign push_ok = push & ~cnt_full(count_q);
   assign pop_ok  = pop & (count_q != '0);

   always_comb begin
      count_next = count_q;
      if (rst | clr) begin
         count_next = '0;
      end else if (push_ok & ~pop_ok) begin
         count_next = count_q + cnt_t'(1);
      end else if (pop_ok & ~push_ok) begin
         count_next = count_q - cnt_t'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst | clr) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= ~wr_ptr;
         if (pop_ok)  rd_ptr <= ~rd_ptr;
      end
      count_q <= count_next;
   end

   // Payload storage needs no reset; empty entries are masked at the top.
   always_ff @(posedge clk) begin
      if (push_ok & ~rst & ~clr) mem[wr_ptr] <= wr_entry;
   end

   assign head  = mem[rd_ptr];
   assign count = count_q;

endmodule

// File: rtl/if_id.sv
// IF/ID pipeline stage: fetch pairs to decode under valid/ready with flush.
// IF_ID_SKID_EN selects the 2-entry skid buffer; otherwise a single register.
module if_id
   import if_id_pkg::*;
#(
   parameter int unsigned DEPTH = IfIdDepth
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [InstAddrBus-1:0] if_pc,
   input  logic [InstBus-1:0]     if_inst,
   input  logic                   if_valid,
   output logic                   if_ready,
   input  logic                   flush,
   output logic [InstAddrBus-1:0] id_pc,
   output logic [InstBus-1:0]     id_inst,
   output logic                   id_valid,
   input  logic                   id_ready
);

   if (DEPTH != IfIdDepth) begin : g_bad_depth
      $error("if_id: only DEPTH == 2 is supported");
   end

   if_id_entry_t head;
   logic         push;
   logic         pop;

`ifdef IF_ID_SKID_EN
   cnt_t count;
   cnt_t count_next;
   logic ready_q;

   assign if_ready = ready_q;
   assign push     = (if_valid == ChipEnable) & ready_q & ~flush;
   assign pop      = id_valid & id_ready & ~flush;
   assign id_valid = (count != '0);

   if_id_skid #(
      .DEPTH(DEPTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .push      (push),
      .pop       (pop),
      .wr_entry  ('{pc: if_pc, inst: if_inst}),
      .head      (head),
      .count     (count),
      .count_next(count_next)
   );

   // Registered ready breaks any path from id_ready back to the PC stage.
   always_ff @(posedge clk) begin
      ready_q <= ~rst & ~cnt_full(count_next);
   end
`else
   logic       run_q;
   logic       valid_q;
   inst_addr_t pc_q;
   inst_t      inst_q;

   // run_q keeps if_ready low in reset and for the release edge itself.
   assign if_ready = run_q & (~valid_q | id_ready);
   assign push     = (if_valid == ChipEnable) & if_ready & ~flush;
   assign pop      = valid_q & id_ready;
   assign id_valid = valid_q;
   assign head     = '{pc: pc_q, inst: inst_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         run_q   <= 1'b0;
         valid_q <= ChipDisable;
         pc_q    <= ZeroWord;
         inst_q  <= ZeroWord;
      end else begin
         run_q <= 1'b1;
         if (flush) begin
            valid_q <= ChipDisable;
            pc_q    <= ZeroWord;
            inst_q  <= ZeroWord;
         end else if (push) begin
            valid_q <= 1'b1;
            pc_q    <= if_pc;
            inst_q  <= if_inst;
         end else if (pop) begin
            valid_q <= ChipDisable;
         end
      end
   end
`endif

   assign id_pc   = id_valid ? head.pc   : ZeroWord;
   assign id_inst = id_valid ? head.inst : ZeroWord;

endmodule

// File: tb/tb_if_id.sv
// Table-driven bench for if_id with an in-order scoreboard of accepted pairs.
// Expectations follow IF_ID_SKID_EN when it is defined for the build.
module tb_if_id;

   typedef struct {
      logic        r;
      logic        f;
      logic        v;
      logic [31:0] pc;
      logic [31:0] inst;
      logic        dr;
      logic        ir;
      logic        iv;
      logic [31:0] opc;
      logic [31:0] oinst;
   } vec_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } pair_t;

   logic        clk;
   logic        rst;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_valid;
   logic        if_ready;
   logic        flush;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_valid;
   logic        id_ready;

   vec_t  tbl[$];
   pair_t sbq[$];
   int    checks = 0;
   int    errors = 0;

   if_id dut (
      .clk     (clk),
      .rst     (rst),
      .if_pc   (if_pc),
      .if_inst (if_inst),
      .if_valid(if_valid),
      .if_ready(if_ready),
      .flush   (flush),
      .id_pc   (id_pc),
      .id_inst (id_inst),
      .id_valid(id_valid),
      .id_ready(id_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic f, input logic v, input logic [31:0] pc,
                      input logic [31:0] inst, input logic dr, input logic ir, input logic iv,
                      input logic [31:0] opc, input logic [31:0] oinst);
      vec_t t;
      t.r = r; t.f = f; t.v = v; t.pc = pc; t.inst = inst; t.dr = dr;
      t.ir = ir; t.iv = iv; t.opc = opc; t.oinst = oinst;
      tbl.push_back(t);
   endtask

   task automatic chk(input string name, input int row, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
      end
   endtask

   initial begin
      pair_t p;
      // Reset held three cycles, release, then a plain three-pair stream.
      //   r  f  v  pc           inst         dr ir iv opc          oinst
      add(1, 0, 0, 32'h0,       32'h0,       0, 0, 0, 32'h0,       32'h0);
      add(1, 0, 0, 32'h0,       32'h0,       0, 0, 0, 32'h0,       32'h0);
      add(1, 0, 0, 32'h0,       32'h0,       0, 0, 0, 32'h0,       32'h0);
      add(0, 0, 0, 32'h0,       32'h0,       0, 0, 0, 32'h0,       32'h0);
      add(0, 0, 0, 32'h0,       32'h0,       0, 1, 0, 32'h0,       32'h0);
      add(0, 0, 1, 32'h0,       32'h11,      1, 1, 0, 32'h0,       32'h0);
      add(0, 0, 1, 32'h4,       32'h22,      1, 1, 1, 32'h0,       32'h11);
      add(0, 0, 1, 32'h8,       32'h33,      1, 1, 1, 32'h4,       32'h22);
      add(0, 0, 0, 32'h0,       32'h0,       1, 1, 1, 32'h8,       32'h33);
      add(0, 0, 0, 32'h0,       32'h0,       0, 1, 0, 32'h0,       32'h0);
`ifdef IF_ID_SKID_EN
      // Fill to two, stall, single pop re-raises ready one cycle later.
      add(0, 0, 1, 32'h0,       32'hA0,      0, 1, 0, 32'h0,       32'h0);
      add(0, 0, 1, 32'h4,       32'hA4,      0, 1, 1, 32'h0,       32'hA0);
      add(0, 0, 0, 32'h0,       32'h0,       0, 0, 1, 32'h0,       32'hA0);
      add(0, 0, 0, 32'h0,       32'h0,       1, 0, 1, 32'h0,       32'hA0);
      add(0, 0, 0, 32'h0,       32'h0,       0, 1, 1, 32'h4,       32'hA4);
      // Refill to two, then flush with an incoming pair on the same edge.
      add(0, 0, 1, 32'h8,       32'hB8,      0, 1, 1, 32'h4,       32'hA4);
      add(0, 1, 1, 32'hDEAD0,   32'hDEAD,    0, 0, 1, 32'h4,       32'hA4);
      add(0, 0, 0, 32'h0,       32'h0,       0, 1, 0, 32'h0,       32'h0);
      // Push and pop together at count 1: head moves to the new entry.
      add(0, 0, 1, 32'h8,       32'h88,      0, 1, 0, 32'h0,       32'h0);
      add(0, 0, 1, 32'hC,       32'hCC,      1, 1, 1, 32'h8,       32'h88);
      add(0, 0, 0, 32'h0,       32'h0,       0, 1, 1, 32'hC,       32'hCC);
      add(0, 0, 0, 32'h0,       32'h0,       1, 1, 1, 32'hC,       32'hCC);
      add(0, 0, 0, 32'h0,       32'h0,       0, 1, 0, 32'h0,       32'h0);
      // Reset mid-operation drops the entry and pulls ready low.
      add(0, 0, 1, 32'h10,      32'h1010,    0, 1, 0, 32'h0,       32'h0);
      add(1, 0, 1, 32'h14,      32'h1414,    0, 1, 1, 32'h10,      32'h1010);
      add(0, 0, 0, 32'h0,       32'h0,       0, 0, 0, 32'h0,       32'h0);
      add(0, 0, 0, 32'h0,       32'h0,       0, 1, 0, 32'h0,       32'h0);
`else
      // Stall: ready tracks ~id_valid | id_ready in the same cycle.
      add(0, 0, 1, 32'h0,       32'hA0,      0, 1, 0, 32'h0,       32'h0);
      add(0, 0, 1, 32'h4,       32'hA4,      0, 0, 1, 32'h0,       32'hA0);
      add(0, 0, 1, 32'h4,       32'hA4,      1, 1, 1, 32'h0,       32'hA0);
      add(0, 0, 0, 32'h0,       32'h0,       0, 0, 1, 32'h4,       32'hA4);
      add(0, 0, 0, 32'h0,       32'h0,       1, 1, 1, 32'h4,       32'hA4);
      // Flush with an incoming pair on the same edge.
      add(0, 0, 1, 32'h8,       32'hB8,      0, 1, 0, 32'h0,       32'h0);
      add(0, 1, 1, 32'hDEAD0,   32'hDEAD,    1, 1, 1, 32'h8,       32'hB8);
      add(0, 0, 0, 32'h0,       32'h0,       0, 1, 0, 32'h0,       32'h0);
      // Back-to-back replace while decode consumes.
      add(0, 0, 1, 32'h8,       32'h88,      0, 1, 0, 32'h0,       32'h0);
      add(0, 0, 1, 32'hC,       32'hCC,      1, 1, 1, 32'h8,       32'h88);
      add(0, 0, 0, 32'h0,       32'h0,       0, 0, 1, 32'hC,       32'hCC);
      add(0, 0, 0, 32'h0,       32'h0,       1, 1, 1, 32'hC,       32'hCC);
      add(0, 0, 0, 32'h0,       32'h0,       0, 1, 0, 32'h0,       32'h0);
      // Reset mid-operation drops the entry and pulls ready low.
      add(0, 0, 1, 32'h10,      32'h1010,    0, 1, 0, 32'h0,       32'h0);
      add(1, 0, 1, 32'h14,      32'h1414,    0, 0, 1, 32'h10,      32'h1010);
      add(0, 0, 0, 32'h0,       32'h0,       0, 0, 0, 32'h0,       32'h0);
      add(0, 0, 0, 32'h0,       32'h0,       0, 1, 0, 32'h0,       32'h0);
`endif

      rst      = 1'b1;
      flush    = 1'b0;
      if_valid = 1'b0;
      if_pc    = '0;
      if_inst  = '0;
      id_ready = 1'b0;
      @(posedge clk);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst      = tbl[i].r;
         flush    = tbl[i].f;
         if_valid = tbl[i].v;
         if_pc    = tbl[i].pc;
         if_inst  = tbl[i].inst;
         id_ready = tbl[i].dr;
         #1;
         chk("if_ready", i, {31'b0, if_ready}, {31'b0, tbl[i].ir});
         chk("id_valid", i, {31'b0, id_valid}, {31'b0, tbl[i].iv});
         chk("id_pc",    i, id_pc,   tbl[i].opc);
         chk("id_inst",  i, id_inst, tbl[i].oinst);
         if (tbl[i].r || tbl[i].f) begin
            sbq.delete();
         end else begin
            if (id_valid === 1'b1 && tbl[i].dr) begin
               if (sbq.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_order row %0d: got pc %h, expected no output", i, id_pc);
               end else begin
                  p = sbq.pop_front();
                  chk("sb_pc",   i, id_pc,   p.pc);
                  chk("sb_inst", i, id_inst, p.inst);
               end
            end
            if (tbl[i].v && tbl[i].ir) sbq.push_back('{pc: tbl[i].pc, inst: tbl[i].inst});
         end
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
